multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: IF/ID/EX/MEM/WB/TRAP with Moore-style registered strobes.
// Optional bus-wait timeout trap is enabled by defining SEQ_BUS_TIMEOUT_EN.
`default_nettype none

module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       alu_en,
    output logic       rf_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OPIMM  = 4'd7,
        CLS_OP     = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_SYSTEM = 4'd10,
        CLS_ILL    = 4'd11
    } cls_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic cls_t decode_class(input logic [6:0] op);
        case (op)
            7'b0110111: decode_class = CLS_LUI;
            7'b0010111: decode_class = CLS_AUIPC;
            7'b1101111: decode_class = CLS_JAL;
            7'b1100111: decode_class = CLS_JALR;
            7'b1100011: decode_class = CLS_BRANCH;
            7'b0000011: decode_class = CLS_LOAD;
            7'b0100011: decode_class = CLS_STORE;
            7'b0010011: decode_class = CLS_OPIMM;
            7'b0110011: decode_class = CLS_OP;
            7'b0001111: decode_class = CLS_FENCE;
            7'b1110011: decode_class = CLS_SYSTEM;
            default:    decode_class = CLS_ILL;
        endcase
    endfunction

    function automatic logic writes_rf(input cls_t cls);
        case (cls)
            CLS_STORE, CLS_BRANCH, CLS_FENCE: writes_rf = 1'b0;
            default:                          writes_rf = 1'b1;
        endcase
    endfunction

    function automatic logic redirects_pc(input cls_t cls, input logic taken);
        case (cls)
            CLS_JAL, CLS_JALR: redirects_pc = 1'b1;
            CLS_BRANCH:        redirects_pc = taken;
            default:           redirects_pc = 1'b0;
        endcase
    endfunction

    state_t state_r, state_n;
    cls_t   class_r, class_n;
    logic   taken_r, taken_n;
    logic   timeout_s;

    assign state = state_r;
    // Acks are qualified by the registered request, so stray or late acks are ignored.
    assign ir_we = imem_req & imem_ack;

`ifdef SEQ_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             wait_s;

    // Bus-wait counter: counts unanswered request cycles, clears whenever the wait ends.
    always_comb begin
        wait_s    = ((state_r == ST_IF) && imem_req && !imem_ack) ||
                    ((state_r == ST_MEM) && dmem_req && !dmem_ack);
        timeout_s = 1'b0;
        cnt_n     = '0;
        if (wait_s) begin
            if (cnt_r == CNT_LAST) begin
                timeout_s = 1'b1;
                cnt_n     = '0;
            end else begin
                timeout_s = 1'b0;
                cnt_n     = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_n = '0;
        end
    end

    // Timeout counter and sticky bus error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            bus_err <= 1'b0;
        end else begin
            cnt_r   <= cnt_n;
            bus_err <= bus_err | timeout_s;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state, class and branch-latch logic.
    always_comb begin
        state_n = state_r;
        class_n = class_r;
        taken_n = taken_r;
        case (state_r)
            ST_IF: begin
                if (imem_req && imem_ack) state_n = ST_ID;
                else                      state_n = ST_IF;
            end
            ST_ID: begin
                class_n = decode_class(opcode);
                if (class_n == CLS_SYSTEM || class_n == CLS_ILL) state_n = ST_TRAP;
                else                                               state_n = ST_EX;
            end
            ST_EX: begin
                if (class_r == CLS_BRANCH) taken_n = branch_taken;
                else                       taken_n = taken_r;
                if (class_r == CLS_LOAD || class_r == CLS_STORE) state_n = ST_MEM;
                else                                               state_n = ST_WB;
            end
            ST_MEM: begin
                if (dmem_req && dmem_ack) state_n = ST_WB;
                else                      state_n = ST_MEM;
            end
            ST_WB:   state_n = ST_IF;
            ST_TRAP: state_n = ST_TRAP;
            default: state_n = ST_TRAP;
        endcase
        if (timeout_s) state_n = ST_TRAP;
        else           state_n = state_n;
    end

    // FSM state plus strobes registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IF;
            class_r  <= CLS_OP;
            taken_r  <= 1'b0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            alu_en   <= 1'b0;
            rf_we    <= 1'b0;
            pc_we    <= 1'b0;
            pc_sel   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_r  <= state_n;
            class_r  <= class_n;
            taken_r  <= taken_n;
            imem_req <= (state_n == ST_IF);
            dmem_req <= (state_n == ST_MEM);
            dmem_we  <= (state_n == ST_MEM) && (class_n == CLS_STORE);
            alu_en   <= (state_n == ST_EX);
            rf_we    <= (state_n == ST_WB) && writes_rf(class_n);
            pc_we    <= (state_n == ST_WB);
            pc_sel   <= (state_n == ST_WB) && redirects_pc(class_n, taken_n);
            illegal  <= illegal | (state_n == ST_TRAP);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; inputs change and outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps

module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       alu_en;
    logic       rf_we;
    logic       pc_we;
    logic       pc_sel;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_en(alu_en), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the first IF cycle with imem_req high.
    task automatic reset_dut();
        rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, illegal, bus_err, ir_we} !== 10'd0 ||
            state !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d req=%b exp state=0 all strobes 0", state, imem_req);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req got %b exp 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || state !== 3'd0) begin
            errors++;
            $display("FAIL first_fetch req=%b state=%0d exp req=1 state=0", imem_req, state);
        end
    endtask

    task automatic test_addi();
        reset_dut();
        opcode = 7'b0010011; imem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || ir_we !== 1'b1) begin
            errors++;
            $display("FAIL addi_c1 state=%0d ir_we=%b exp 0/1", state, ir_we);
        end
        tick(); imem_ack = 1'b0;
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b0 || alu_en !== 1'b0) begin
            errors++;
            $display("FAIL addi_c2 state=%0d req=%b alu=%b exp 1/0/0", state, imem_req, alu_en);
        end
        tick();
        checks++;
        if (state !== 3'd2 || alu_en !== 1'b1) begin
            errors++;
            $display("FAIL addi_c3 state=%0d alu_en=%b exp 2/1", state, alu_en);
        end
        tick();
        checks++;
        if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0 || alu_en !== 1'b0) begin
            errors++;
            $display("FAIL addi_c4 state=%0d rf=%b pc_we=%b sel=%b alu=%b exp 4/1/1/0/0",
                     state, rf_we, pc_we, pc_sel, alu_en);
        end
        tick();
        checks++;
        if (state !== 3'd0 || imem_req !== 1'b1 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL addi_c5 state=%0d req=%b pc_we=%b rf=%b exp 0/1/0/0", state, imem_req, pc_we, rf_we);
        end
    endtask

    task automatic test_load_wait();
        int req_cycles;
        int total;
        reset_dut();
        opcode = 7'b0000011; imem_ack = 1'b1;
        total = 1;
        tick(); imem_ack = 1'b0; total++;
        tick(); total++;
        tick(); total++;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (dmem_req === 1'b1 && dmem_we === 1'b0 && state === 3'd3) req_cycles++;
            if (i == 3) dmem_ack = 1'b1;
            else        dmem_ack = 1'b0;
            tick();
            if (i != 3) total++;
        end
        dmem_ack = 1'b0;
        total++;
        checks++;
        if (req_cycles !== 4) begin
            errors++;
            $display("FAIL lw_req_cycles got %0d exp 4", req_cycles);
        end
        checks++;
        if (state !== 3'd4 || rf_we !== 1'b1 || dmem_req !== 1'b0 || pc_sel !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb state=%0d rf=%b dreq=%b sel=%b exp 4/1/0/0", state, rf_we, dmem_req, pc_sel);
        end
        tick();
        checks++;
        if (state !== 3'd0 || total !== 8) begin
            errors++;
            $display("FAIL lw_total state=%0d cycles=%0d exp 0/8", state, total);
        end
    endtask

    task automatic test_branch();
        logic [1:0] tk;
        tk = 2'b01;
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            opcode = 7'b1100011; imem_ack = 1'b1;
            tick(); imem_ack = 1'b0;
            tick();
            branch_taken = tk[r];
            tick();
            branch_taken = ~tk[r];
            checks++;
            if (state !== 3'd4 || pc_sel !== tk[r] || rf_we !== 1'b0 || pc_we !== 1'b1) begin
                errors++;
                $display("FAIL beq_wb_%0d state=%0d sel=%b rf=%b pc_we=%b exp 4/%b/0/1",
                         r, state, pc_sel, rf_we, pc_we, tk[r]);
            end
            tick();
            branch_taken = 1'b0;
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic       mem;
        logic       we;
        logic       rf;
        logic       sel;
    } cls_vec_t;

    task automatic test_classes();
        cls_vec_t v[7];
        v[0] = '{7'b0110111, 1'b0, 1'b0, 1'b1, 1'b0};
        v[1] = '{7'b0010111, 1'b0, 1'b0, 1'b1, 1'b0};
        v[2] = '{7'b1101111, 1'b0, 1'b0, 1'b1, 1'b1};
        v[3] = '{7'b1100111, 1'b0, 1'b0, 1'b1, 1'b1};
        v[4] = '{7'b0110011, 1'b0, 1'b0, 1'b1, 1'b0};
        v[5] = '{7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0};
        v[6] = '{7'b0100011, 1'b1, 1'b1, 1'b0, 1'b0};
        reset_dut();
        for (int k = 0; k < 7; k++) begin
            opcode = v[k].op; imem_ack = 1'b1;
            tick(); imem_ack = 1'b0;
            tick();
            opcode = 7'b1111111;
            checks++;
            if (state !== 3'd2 || alu_en !== 1'b1) begin
                errors++;
                $display("FAIL cls%0d_ex state=%0d alu=%b exp 2/1", k, state, alu_en);
            end
            tick();
            if (v[k].mem) begin
                checks++;
                if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== v[k].we || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL cls%0d_mem state=%0d dreq=%b dwe=%b ireq=%b exp 3/1/%b/0",
                             k, state, dmem_req, dmem_we, imem_req, v[k].we);
                end
                dmem_ack = 1'b1;
                tick();
                dmem_ack = 1'b0;
            end
            checks++;
            if (state !== 3'd4 || rf_we !== v[k].rf || pc_sel !== v[k].sel || pc_we !== 1'b1 || dmem_we !== 1'b0) begin
                errors++;
                $display("FAIL cls%0d_wb state=%0d rf=%b sel=%b pc_we=%b exp 4/%b/%b/1",
                         k, state, rf_we, pc_sel, pc_we, v[k].rf, v[k].sel);
            end
            tick();
        end
    endtask

    task automatic test_trap();
        logic [6:0] ops[2];
        int bad;
        ops[0] = 7'b1111111;
        ops[1] = 7'b1110011;
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            opcode = ops[t]; imem_ack = 1'b1;
            tick(); imem_ack = 1'b0;
            tick();
            checks++;
            if (state !== 3'd5 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL trap%0d_entry state=%0d illegal=%b exp 5/1", t, state, illegal);
            end
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                imem_ack = c[0];
                dmem_ack = ~c[0];
                #1;
                if (state !== 3'd5 || illegal !== 1'b1 || pc_we !== 1'b0 || rf_we !== 1'b0 ||
                    imem_req !== 1'b0 || dmem_req !== 1'b0 || alu_en !== 1'b0 || ir_we !== 1'b0) bad++;
                tick();
            end
            imem_ack = 1'b0; dmem_ack = 1'b0;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL trap%0d_hold bad_cycles=%0d exp 0", t, bad);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        reset_dut();
        opcode = 7'b0100011; imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem state=%0d dreq=%b dwe=%b exp 3/1/1", state, dmem_req, dmem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || {imem_req, dmem_req, dmem_we, alu_en, rf_we, pc_we, pc_sel, ir_we} !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset state=%0d dreq=%b dwe=%b exp 0/0/0", state, dmem_req, dmem_we);
        end
        dmem_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0 || imem_req !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack state=%0d ireq=%b dreq=%b exp 0/1/0", state, imem_req, dmem_req);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        reset_dut();
`ifdef SEQ_BUS_TIMEOUT_EN
        repeat (15) tick();
        checks++;
        if (state !== 3'd0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early state=%0d bus_err=%b exp 0/0", state, bus_err);
        end
        tick();
        checks++;
        if (state !== 3'd5 || bus_err !== 1'b1 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL timeout_trap state=%0d bus_err=%b illegal=%b exp 5/1/1", state, bus_err, illegal);
        end
`else
        repeat (40) tick();
        checks++;
        if (state !== 3'd0 || bus_err !== 1'b0 || imem_req !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout state=%0d bus_err=%b req=%b exp 0/0/1", state, bus_err, imem_req);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_classes();
        test_trap();
        test_reset_mid_op();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
